// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST inference engine datapath.
package mnist_pkg;

  // Native accumulator/activation word width of the hidden layer.
  localparam int ACT_W = 32;

  // Signed activation word as produced by the hidden-layer accumulators.
  typedef logic signed [ACT_W-1:0] act_t;

endpackage : mnist_pkg

// File: rtl/relu_core.sv
// Purely combinational ReLU with an optional upper clip.
// A negative input gives 0. A non-negative input above a non-zero CLIP gives
// CLIP. Any other input passes through unchanged.
module relu_core #(
  parameter int          WIDTH = 32,
  parameter int unsigned CLIP  = 0
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  // Clipping is compiled out entirely when CLIP is zero.
  localparam bit               CLIP_EN = (CLIP != 32'd0);
  localparam logic [WIDTH-1:0] CLIP_V  = WIDTH'(CLIP);

  // Rectify first, then clip. The magnitude compare is unsigned because it is
  // only reached when the sign bit is already clear.
  always_comb begin
    y_o = '0;
    if (x_i[WIDTH-1]) begin
      y_o = '0;
    end else if (CLIP_EN && (x_i > CLIP_V)) begin
      y_o = CLIP_V;
    end else begin
      y_o = x_i;
    end
  end

endmodule : relu_core

// File: rtl/pe_relu.sv
// Hidden-layer ReLU element. It has a combinational result path, a
// one-stage registered result path with a valid flag, and a saturating
// counter of valid negative inputs for sparsity statistics.
module pe_relu
  import mnist_pkg::*;
#(
  parameter int          WIDTH = ACT_W,
  parameter int unsigned CLIP  = 0,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] neg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] relu_s;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] res_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_neg_s;

  // A single core feeds both the combinational output and the result register.
  relu_core #(
    .WIDTH (WIDTH),
    .CLIP  (CLIP)
  ) u_core (
    .x_i (in),
    .y_o (relu_s)
  );

  assign out      = relu_s;
  assign is_neg_s = in[WIDTH-1];

  // The result register loads only on a valid input and holds otherwise.
  always_comb begin
    res_d = res_q;
    if (in_valid) begin
      res_d = relu_s;
    end else begin
      res_d = res_q;
    end
  end

  // Clear takes priority over counting. The count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (in_valid && is_neg_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers. Reset clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= in_valid;
      cnt_q <= cnt_d;
    end
  end

  assign out_q     = res_q;
  assign out_valid = vld_q;
  assign neg_cnt   = cnt_q;

endmodule : pe_relu

// File: tb/tb_pe_relu.sv
// Self-checking bench for pe_relu. Three instances share one stimulus:
//   dut0: default parameters (CLIP = 0, CNT_W = 16)
//   dutc: CLIP = 100
//   duts: CNT_W = 2, used for the counter saturation check
// Registered results from dut0 are checked through an expected-value queue
// that a separate monitor process drains.
module tb_pe_relu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_s = 32'd0;
  logic        in_valid_s = 1'b0;
  logic        clr_s = 1'b0;

  logic [31:0] out0, outq0, outc, outqc, outs, outqs;
  logic        vld0, vldc, vlds;
  logic [15:0] cnt0, cntc;
  logic [1:0]  cnts;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pe_relu dut0 (
    .clk(clk), .rst(rst), .in(in_s), .out(out0), .in_valid(in_valid_s),
    .out_q(outq0), .out_valid(vld0), .clr_cnt(clr_s), .neg_cnt(cnt0)
  );

  pe_relu #(.CLIP(100)) dutc (
    .clk(clk), .rst(rst), .in(in_s), .out(outc), .in_valid(in_valid_s),
    .out_q(outqc), .out_valid(vldc), .clr_cnt(clr_s), .neg_cnt(cntc)
  );

  pe_relu #(.CNT_W(2)) duts (
    .clk(clk), .rst(rst), .in(in_s), .out(outs), .in_valid(in_valid_s),
    .out_q(outqs), .out_valid(vlds), .clr_cnt(clr_s), .neg_cnt(cnts)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one input on the falling edge. A valid input queues the
  // expected registered result for dut0 (no clipping).
  task automatic drive(input logic [31:0] v, input logic vld, input logic clr);
    @(negedge clk);
    in_s       = v;
    in_valid_s = vld;
    clr_s      = clr;
    if (vld) exp_q.push_back(v[31] ? 32'd0 : v);
  endtask

  // Monitor: compares each registered result from dut0 against the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (vld0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got out_q 0x%08h, expected no valid output", outq0);
        end else begin
          check("sb_out_q", outq0, exp_q.pop_front());
        end
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] e0;
    logic [31:0] ec;

    // Reset state.
    @(posedge clk);
    #2;
    check("rst_out_q", outq0, 32'd0);
    check("rst_out_valid", {31'd0, vld0}, 32'd0);
    check("rst_neg_cnt", {16'd0, cnt0}, 32'd0);
    check("rst_neg_cnt_sat", {30'd0, cnts}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Combinational sweep: 0, 10, -20, -30, 40, 50, -60, ... -190, 200, 210.
    for (int i = 0; i < 22; i++) begin
      v = 32'(i * 10);
      if ((i % 4) == 2 || (i % 4) == 3) begin
        drive(-v, 1'b0, 1'b0);
        e0 = 32'd0;
        ec = 32'd0;
      end else begin
        drive(v, 1'b0, 1'b0);
        e0 = v;
        ec = (v > 32'd100) ? 32'd100 : v;
      end
      #1;
      check("sweep_out", out0, e0);
      check("sweep_out_clip", outc, ec);
    end

    // Extremes.
    drive(32'h8000_0000, 1'b0, 1'b0); #1;
    check("min_neg", out0, 32'd0);
    drive(32'h7FFF_FFFF, 1'b0, 1'b0); #1;
    check("max_pos", out0, 32'h7FFF_FFFF);
    check("max_pos_clip", outc, 32'd100);
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); #1;
    check("minus_one", out0, 32'd0);

    // Clip boundaries with CLIP = 100.
    drive(32'd99, 1'b0, 1'b0);  #1; check("clip_99", outc, 32'd99);
    drive(32'd100, 1'b0, 1'b0); #1; check("clip_100", outc, 32'd100);
    drive(32'd101, 1'b0, 1'b0); #1; check("clip_101", outc, 32'd100);
    drive(32'd210, 1'b0, 1'b0); #1; check("clip_210", outc, 32'd100);
    drive(-32'd5, 1'b0, 1'b0);  #1; check("clip_neg5", outc, 32'd0);

    // Registered path: 10, -20, 40, then one idle cycle.
    drive(32'd10, 1'b1, 1'b0);
    drive(-32'd20, 1'b1, 1'b0);
    drive(32'd40, 1'b1, 1'b0);
    drive(32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("idle_out_valid", {31'd0, vld0}, 32'd0);
    check("idle_out_q_hold", outq0, 32'd40);

    // Counter: 5 valid negatives, 3 valid positives, 2 invalid negatives.
    drive(32'd0, 1'b0, 1'b1);
    for (int k = 1; k <= 5; k++) drive(-32'(k), 1'b1, 1'b0);
    drive(32'd7, 1'b1, 1'b0);
    drive(32'd8, 1'b1, 1'b0);
    drive(32'd40, 1'b1, 1'b0);
    drive(-32'd9, 1'b0, 1'b0);
    drive(-32'd9, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("cnt_five", {16'd0, cnt0}, 32'd5);
    check("cnt_sat", {30'd0, cnts}, 32'd3);
    check("pre_rst_out_q", outq0, 32'd40);

    // Asynchronous reset asserted between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_q", outq0, 32'd0);
    check("arst_out_valid", {31'd0, vld0}, 32'd0);
    check("arst_neg_cnt", {16'd0, cnt0}, 32'd0);
    check("arst_neg_cnt_sat", {30'd0, cnts}, 32'd0);
    in_s = 32'd77;
    #1;
    check("arst_out_tracks_pos", out0, 32'd77);
    in_s = -32'd3;
    #1;
    check("arst_out_tracks_neg", out0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clear has priority over a simultaneous valid negative.
    drive(-32'd1, 1'b1, 1'b0);
    @(posedge clk); #2;
    check("cnt_one", {16'd0, cnt0}, 32'd1);
    drive(-32'd2, 1'b1, 1'b1);
    @(posedge clk); #2;
    check("clr_priority", {16'd0, cnt0}, 32'd0);
    drive(32'd0, 1'b0, 1'b0);
    @(posedge clk); #2;

    // Every queued result must have been seen.
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pe_relu

// File: doc/pe_relu.md
# pe_relu

Signed rectified-linear activation element for the hidden-layer datapath of the MNIST inference engine. It takes one signed accumulator word from the hidden-layer buffer and returns `max(in, 0)`, with an optional upper clip. It provides two result paths: a combinational result used directly by the hidden-layer buffer, and a one-stage registered result with a valid flag for pipelined consumers. A saturating negative-input counter supports activation-sparsity statistics.

## Interface
- `WIDTH`, 32: data width; signed two's complement in, non-negative out.
- `CLIP`, 0: upper clip value for the output; 0 disables clipping; legal range 0..2^(WIDTH-1)-1.
- `CNT_W`, 16: width of the negative-input counter.

- `clk`  in  1  single clock; all registers are rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in`  in  WIDTH  signed activation input.
- `out`  out  WIDTH  combinational ReLU result of `in`.
- `in_valid`  in  1  qualifies `in` for the registered path and counter.
- `out_q`  out  WIDTH  registered ReLU result.
- `out_valid`  out  1  `out_q` holds a result captured from a valid input.
- `clr_cnt`  in  1  synchronous clear of `neg_cnt`.
- `neg_cnt`  out  CNT_W  number of valid inputs with value < 0; saturating.

## Operation
- Core function f(x):
  - x[WIDTH-1] = 1, i.e. negative → 0.
  - Otherwise, if CLIP ≠ 0 and x > CLIP → CLIP.
  - Otherwise → x unchanged.
- x = 0 gives 0; it is not counted as negative.
- The most negative value (0x8000_0000 for WIDTH = 32) gives 0.
- The most positive value (0x7FFF_FFFF) passes through unchanged when CLIP = 0.
- `out` = f(`in`) at all times, independent of `clk`, `rst` and `in_valid`.
- Registered path, on each rising edge:
  - `out_valid` ← `in_valid`.
  - If `in_valid`, `out_q` ← f(`in`); otherwise `out_q` holds its value.
- Counter, on each rising edge:
  - If `clr_cnt`, `neg_cnt` ← 0. `clr_cnt` has priority over a simultaneous count event.
  - Else if `in_valid` and `in` < 0, `neg_cnt` ← `neg_cnt` + 1, saturating at 2^CNT_W − 1 (no wrap).
- Reset values:
  - `out_q` = 0, `out_valid` = 0, `neg_cnt` = 0.
  - `out` is unaffected by reset and still tracks `in`.
- No state machine; no backpressure. The consumer must accept `out_q` in the cycle in which `out_valid` is high.

## Timing
- `out`: zero-cycle combinational latency; it settles within the same evaluation as a change on `in`.
- `out_q` / `out_valid`: latency of 1 cycle from a sampled `in` / `in_valid`. Throughput is one result per cycle.
- `neg_cnt` reflects an input one cycle after it is sampled.
- Reset asserted mid-stream:
  - `out_q`, `out_valid` and `neg_cnt` clear immediately and asynchronously.
  - On the first rising edge after deassertion, normal sampling resumes.
- `in` changing between edges affects only `out`.

## Structure
- Shared package `mnist_pkg`: `ACT_W` = 32, used as the default for `WIDTH`; typedef `act_t` = logic signed [ACT_W-1:0].
- One sub-module is natural: `relu_core`, the purely combinational f(x) with the `WIDTH`/`CLIP` parameters. It is instantiated once and drives both `out` and the D input of `out_q`.
- The top level contains the output register, the valid register and the saturating counter.

## Test plan
- Combinational sweep, CLIP = 0: apply 0, 10, −20, −30, 40, 50, −60, …, −190, 200, 210, one value every 10 ns. Required: `out` = value for the positives, 0 for the negatives, and 0 for the initial 0.
- Extremes: `in` = 0x8000_0000 → `out` = 0; `in` = 0x7FFF_FFFF → `out` = 0x7FFF_FFFF; `in` = 0xFFFF_FFFF (−1) → 0.
- Clip, CLIP = 100: `in` = 99 → 99; 100 → 100; 101 → 100; 210 → 100; −5 → 0.
- Registered path:
  - Stream 10, −20, 40 with `in_valid` high, then one idle cycle.
  - Required `out_q` on successive edges: 10, 0, 40, then 40 held.
  - Required `out_valid`: 1, 1, 1, 0.
- Counter:
  - Apply 5 valid negatives, 3 valid positives and 2 negatives with `in_valid` low → `neg_cnt` = 5.
  - Assert `clr_cnt` together with a valid negative → `neg_cnt` = 0.
  - With CNT_W = 2, 6 negatives → `neg_cnt` = 3 (saturated).
- Asynchronous reset: assert `rst` between edges while `out_q` = 40 and `neg_cnt` = 5.
  - Required: `out_q`, `out_valid` and `neg_cnt` go to 0 before the next edge.
  - `out` keeps tracking `in` throughout reset.
